controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Multicycle control unit for the accumulator CPU; replaces the single-cycle combinational opcode decoder.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and BRANCH states.
- Talks to instruction/data memory through a request/ready handshake with a timeout.
- Drives the datapath strobes (ALUOp, LoadA/LoadB, UseImmediate, PC control); also provides a halt state and a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode width; codes above the defined map are illegal.
- ALUOP_W, 3, ALUOp width.
- TIMEOUT, 15, cycles to wait for MemReady before error; 0 disables the timeout.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- Start  in  1  leave IDLE/HALT, begin fetching
- opcode  in  OPCODE_W  opcode field from the instruction bus; valid during the FETCH cycle with MemReady=1
- Zero  in  1  accumulator-zero flag from the datapath
- Equal  in  1  A==B flag from the datapath
- MemReady  in  1  memory completes the current request this cycle
- MemRead  out  1  read request (fetch or load)
- MemWrite  out  1  write request (STA/STB)
- IRWrite  out  1  latch the instruction word
- PCInc  out  1  PC <= PC+1
- PCLoad  out  1  PC <= branch target
- ALUOp  out  ALUOP_W  ALU function
- LoadA  out  1  write the accumulator
- LoadB  out  1  write register B
- UseImmediate  out  1  ALU B operand = immediate
- IllegalOp  out  1  one-cycle pulse on an undefined opcode
- MemError  out  1  sticky; set on timeout, cleared by reset or Start
- Halted  out  1  FSM is in HALT
- Retired  out  CNT_W  instructions completed; wraps

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, internal opcode register=0, wait counter=0, Retired=0, MemError=0. All strobes are 0 and ALUOp=0 whenever no state below asserts them.
- All strobes are combinational from the registered state, the latched opcode and the MemReady/Zero/Equal inputs.
- Opcode map (fixed, in the shared package):
  - 0000 ADD(ALUOp 000); 0001 SUB(001); 1000 AND(010); 1001 OR(011); 0110 LDC(100, UseImmediate).
  - 0010 LDA; 0100 LDB; 0011 STA; 0101 STB.
  - 0111 JZ; 1010 BEQ; 1111 HLT.
  - 1011-1110 illegal.
- IDLE: no strobes. Start=1 -> FETCH.
- FETCH:
  - MemRead=1.
  - On MemReady=1: IRWrite=1 and PCInc=1 that cycle; opcode captured; -> DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle, no strobes):
  - ALU ops and LDC -> EXEC.
  - LDA/LDB/STA/STB -> MEM.
  - JZ/BEQ -> BRANCH.
  - HLT -> HALT; Retired increments on this transition.
  - Illegal -> IllegalOp=1 this cycle, -> FETCH, Retired unchanged.
- EXEC (1 cycle): ALUOp per map, LoadA=1, UseImmediate=1 for LDC only; -> FETCH.
- MEM:
  - LDA/LDB: MemRead=1. STA/STB: MemWrite=1.
  - Request held until MemReady=1. On that cycle: LoadA=1 for LDA, LoadB=1 for LDB; -> FETCH.
- BRANCH (1 cycle): PCLoad=1 iff (JZ and Zero) or (BEQ and Equal); -> FETCH.
- Retired increments by 1 on every transition out of EXEC, MEM and BRANCH, and on DECODE->HALT. It wraps from all-ones to 0.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH/MEM with MemReady=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with MemReady=0: MemError<=1, all requests drop the next cycle, -> HALT.
  - MemReady arriving in the same cycle the counter hits TIMEOUT counts as success.
- HALT: Halted=1, no strobes. Start=1 -> FETCH and clears MemError.
- Start is ignored in every state except IDLE and HALT.
- rst_n=0 mid-instruction (including with a request pending) aborts immediately: next cycle is IDLE with all strobes 0.
- Strobes are never asserted while state=IDLE or HALT.

Decomposition:
- Package controle_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, EXEC, MEM, BRANCH, HALT);
  - opcode localparams (OP_ADD..OP_HLT);
  - ALUOp localparams (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_PASS=100).
- One sub-module, controle_decode: purely combinational opcode -> {class, ALUOp, UseImmediate, is_load_b, is_store, illegal}. The FSM instantiates it on the latched opcode.

Test Plan:
- Reset, Start, opcode=0000, MemReady=1 in the first FETCH cycle -> IRWrite/PCInc in cycle 1, DECODE in cycle 2, EXEC with ALUOp=000 and LoadA=1 in cycle 3, Retired=1, back to FETCH.
- LDA with MemReady delayed 3 cycles in MEM -> MemRead held 4 cycles, LoadA=1 only in the MemReady cycle; LDB identical but LoadB=1; STA -> MemWrite held, no Load.
- JZ with Zero=1 -> PCLoad=1 in BRANCH; with Zero=0 -> PCLoad=0; BEQ with Equal=1 -> PCLoad=1; each adds 1 to Retired.
- opcode=1100 -> IllegalOp pulses exactly one cycle in DECODE, Retired unchanged, next state FETCH.
- TIMEOUT=15, MemReady held 0 in FETCH -> MemError=1 and Halted=1 after 15 wait cycles; then Start=1 -> MemError=0, FETCH.
- HLT -> Halted=1 and Retired+1; CNT_W=4 with 16 retirements -> Retired wraps to 0; rst_n=0 during MEM wait -> IDLE next cycle, MemRead=0.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Opcode map, ALU function codes, FSM states and decode classes.
package controle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    BRANCH,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    CL_ALU,
    CL_MEM,
    CL_BRANCH,
    CL_HALT
  } opclass_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LDA = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_STB = 4'b0101;
  localparam logic [3:0] OP_LDC = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

endpackage

// File: rtl/controle_decode.sv
// Combinational opcode classifier for the multicycle controller.
// Maps the latched opcode to an instruction class and ALU controls.
module controle_decode
  import controle_pkg::*;
(
  input  logic [3:0] opcode,
  output opclass_t   opClass,
  output logic [2:0] aluOp,
  output logic       useImm,
  output logic       isLoadB,
  output logic       isStore,
  output logic       illegal
);

  always_comb begin
    opClass = CL_ALU;
    aluOp   = ALU_ADD;
    useImm  = 1'b0;
    isLoadB = 1'b0;
    isStore = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: aluOp = ALU_ADD;
      OP_SUB: aluOp = ALU_SUB;
      OP_AND: aluOp = ALU_AND;
      OP_OR:  aluOp = ALU_OR;
      OP_LDC: begin
        aluOp  = ALU_PASS;
        useImm = 1'b1;
      end
      OP_LDA: opClass = CL_MEM;
      OP_LDB: begin
        opClass = CL_MEM;
        isLoadB = 1'b1;
      end
      OP_STA, OP_STB: begin
        opClass = CL_MEM;
        isStore = 1'b1;
      end
      OP_JZ, OP_BEQ: opClass = CL_BRANCH;
      OP_HLT: opClass = CL_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the accumulator CPU.
// Sequences fetch/decode/exec/mem/branch with a memory timeout.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                Zero,
  input  logic                Equal,
  input  logic                MemReady,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCInc,
  output logic                PCLoad,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                LoadA,
  output logic                LoadB,
  output logic                UseImmediate,
  output logic                IllegalOp,
  output logic                MemError,
  output logic                Halted,
  output logic [CNT_W-1:0]    Retired
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state, nextState;
  logic [OPCODE_W-1:0] opReg;
  logic [WAIT_W-1:0]   waitCnt;
  logic                retire, memErrSet, timeoutHit;

  opclass_t   opClass;
  logic [2:0] aluOp;
  logic       useImm, isLoadB, isStore, illegal;

  controle_decode uDecode (
    .opcode (opReg[3:0]),
    .opClass(opClass),
    .aluOp  (aluOp),
    .useImm (useImm),
    .isLoadB(isLoadB),
    .isStore(isStore),
    .illegal(illegal)
  );

  assign timeoutHit = (TIMEOUT != 0) &&
                      (waitCnt == WAIT_W'(TIMEOUT));
  assign Halted = (state == HALT);

  always_comb begin
    nextState    = state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCInc        = 1'b0;
    PCLoad       = 1'b0;
    ALUOp        = '0;
    LoadA        = 1'b0;
    LoadB        = 1'b0;
    UseImmediate = 1'b0;
    IllegalOp    = 1'b0;
    retire       = 1'b0;
    memErrSet    = 1'b0;
    unique case (state)
      IDLE: if (Start) nextState = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCInc     = 1'b1;
          nextState = DECODE;
        end else if (timeoutHit) begin
          memErrSet = 1'b1;
          nextState = HALT;
        end
      end
      DECODE: begin
        if (illegal) begin
          IllegalOp = 1'b1;
          nextState = FETCH;
        end else begin
          unique case (opClass)
            CL_ALU:    nextState = EXEC;
            CL_MEM:    nextState = MEM;
            CL_BRANCH: nextState = BRANCH;
            CL_HALT: begin
              nextState = HALT;
              retire    = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        ALUOp        = ALUOP_W'(aluOp);
        LoadA        = 1'b1;
        UseImmediate = useImm;
        retire       = 1'b1;
        nextState    = FETCH;
      end
      MEM: begin
        MemRead  = !isStore;
        MemWrite = isStore;
        if (MemReady) begin
          LoadA     = !isStore && !isLoadB;
          LoadB     = !isStore && isLoadB;
          retire    = 1'b1;
          nextState = FETCH;
        end else if (timeoutHit) begin
          memErrSet = 1'b1;
          nextState = HALT;
        end
      end
      BRANCH: begin
        PCLoad = (opReg[3:0] == OP_JZ && Zero) ||
                 (opReg[3:0] == OP_BEQ && Equal);
        retire    = 1'b1;
        nextState = FETCH;
      end
      HALT: if (Start) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      opReg    <= '0;
      waitCnt  <= '0;
      Retired  <= '0;
      MemError <= 1'b0;
    end else begin
      state <= nextState;
      if (state == FETCH && MemReady)
        opReg <= opcode;
      // counter restarts whenever FETCH/MEM is (re)entered
      if ((state == FETCH || state == MEM) &&
          nextState == state && !MemReady)
        waitCnt <= waitCnt + 1'b1;
      else
        waitCnt <= '0;
      if (retire)
        Retired <= Retired + 1'b1;
      if ((state == IDLE || state == HALT) && Start)
        MemError <= 1'b0;
      else if (memErrSet)
        MemError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for the multicycle control unit.
// Instance uses CNT_W=4 so the retired counter wrap is reachable.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n, Start, Zero, Equal, MemReady;
  logic [3:0] opcode;
  logic       MemRead, MemWrite, IRWrite, PCInc, PCLoad;
  logic [2:0] ALUOp;
  logic       LoadA, LoadB, UseImmediate, IllegalOp;
  logic       MemError, Halted;
  logic [3:0] Retired;

  int errors = 0;
  int checks = 0;
  int expRet = 0;

  controle_multiciclo #(
    .OPCODE_W(4), .ALUOP_W(3), .TIMEOUT(15), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .opcode(opcode), .Zero(Zero), .Equal(Equal),
    .MemReady(MemReady), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCInc(PCInc), .PCLoad(PCLoad), .ALUOp(ALUOp),
    .LoadA(LoadA), .LoadB(LoadB),
    .UseImmediate(UseImmediate), .IllegalOp(IllegalOp),
    .MemError(MemError), .Halted(Halted),
    .Retired(Retired)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] strobes();
    return {MemRead, MemWrite, IRWrite, PCInc, PCLoad,
            LoadA, LoadB, UseImmediate, IllegalOp, Halted};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkRet(input string tag);
    chk(tag, 32'(Retired), 32'(expRet % 16));
  endtask

  // From FETCH: deliver opcode with MemReady, land in DECODE
  task automatic fetch(input logic [3:0] op);
    opcode = op;
    MemReady = 1'b1;
    #1;
    chk("fetch_irw_pcinc", 32'({MemRead, IRWrite, PCInc}), 32'h7);
    tick();
    MemReady = 1'b0;
    opcode = 4'hx;
    #1;
  endtask

  task automatic aluOp(input logic [3:0] op,
                       input logic [2:0] expAlu,
                       input logic expImm);
    fetch(op);
    chk("decode_quiet", 32'(strobes()), 32'h0);
    tick();
    chk("exec_aluop", 32'(ALUOp), 32'(expAlu));
    chk("exec_loada_imm", 32'({LoadA, UseImmediate}),
        32'({1'b1, expImm}));
    tick();
    expRet++;
    chkRet("exec_retired");
    chk("back_fetch", 32'(MemRead), 32'h1);
  endtask

  task automatic memOp(input logic [3:0] op,
                       input logic expRd, input logic expWr,
                       input logic expLa, input logic expLb);
    fetch(op);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("mem_wait_req", 32'({MemRead, MemWrite, LoadA, LoadB}),
          32'({expRd, expWr, 2'b00}));
      tick();
    end
    MemReady = 1'b1;
    #1;
    chk("mem_ready", 32'({MemRead, MemWrite, LoadA, LoadB}),
        32'({expRd, expWr, expLa, expLb}));
    tick();
    MemReady = 1'b0;
    #1;
    expRet++;
    chkRet("mem_retired");
  endtask

  task automatic brOp(input logic [3:0] op, input logic z,
                      input logic eq, input logic expLoad);
    fetch(op);
    Zero = z;
    Equal = eq;
    tick();
    chk("branch_pcload", 32'(PCLoad), 32'(expLoad));
    tick();
    Zero = 1'b0;
    Equal = 1'b0;
    expRet++;
    chkRet("branch_retired");
  endtask

  initial begin
    int n;
    rst_n = 1'b0; Start = 1'b0; Zero = 1'b0; Equal = 1'b0;
    MemReady = 1'b0; opcode = 4'h0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset_strobes", 32'(strobes()), 32'h0);
    chk("reset_aluop", 32'(ALUOp), 32'h0);
    chk("reset_memerr", 32'(MemError), 32'h0);
    chkRet("reset_retired");

    Start = 1'b1;
    tick();
    Start = 1'b0;
    aluOp(4'b0000, 3'b000, 1'b0);
    aluOp(4'b0001, 3'b001, 1'b0);
    aluOp(4'b1000, 3'b010, 1'b0);
    aluOp(4'b1001, 3'b011, 1'b0);
    aluOp(4'b0110, 3'b100, 1'b1);

    memOp(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
    memOp(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
    memOp(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
    memOp(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);

    brOp(4'b0111, 1'b1, 1'b0, 1'b1);
    brOp(4'b0111, 1'b0, 1'b1, 1'b0);
    brOp(4'b1010, 1'b0, 1'b1, 1'b1);
    brOp(4'b1010, 1'b1, 1'b0, 1'b0);

    fetch(4'b1100);
    chk("illegal_pulse", 32'(IllegalOp), 32'h1);
    tick();
    chk("illegal_one_cycle", 32'(IllegalOp), 32'h0);
    chk("illegal_to_fetch", 32'(MemRead), 32'h1);
    chkRet("illegal_retired");

    fetch(4'b1111);
    tick();
    expRet++;
    chk("hlt_strobes", 32'(strobes()), 32'h1);
    chkRet("hlt_retired");
    Start = 1'b1;
    #1;
    tick();
    Start = 1'b0;
    #1;
    chk("hlt_restart", 32'({MemRead, Halted}), 32'h2);

    n = 0;
    while (MemRead && !Halted && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("timeout_err_halt", 32'({MemError, Halted}), 32'h3);
    chk("timeout_no_req", 32'({MemRead, MemWrite}), 32'h0);
    Start = 1'b1;
    #1;
    tick();
    Start = 1'b0;
    #1;
    chk("err_cleared", 32'({MemError, Halted, MemRead}), 32'h1);

    for (int i = 0; i < 16; i++) begin
      fetch(4'b0000);
      tick();
      tick();
      expRet++;
      chkRet("wrap_retired");
    end

    fetch(4'b0010);
    tick();
    tick();
    chk("mem_pending", 32'(MemRead), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_strobes", 32'(strobes()), 32'h0);
    chk("abort_retired", 32'(Retired), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
